// File: rtl/shift_deserializer.sv
// rtl/shift_deserializer.sv - LSB-first serial-to-parallel stage with one-word skid slot
//
// Purpose:
//   Shifts the serial bit stream in LSB-first and assembles WIDTH-bit words.
//   Each finished word goes out on a valid/ready parallel port. If the
//   consumer stalls, one more finished word is held in the shift register.
//   The serial side is back-pressured only when both the output slot and the
//   shift register hold a word.
//
// Ports:
//   clk         in   1        rising-edge clock
//   rst         in   1        asynchronous active-high reset
//   sin         in   1        serial data bit
//   sin_valid   in   1        sin carries a bit this cycle
//   sin_ready   out  1        block accepts a bit this cycle (combinational)
//   flush       in   1        synchronous discard of the partial or held word
//   pout        out  WIDTH    assembled word, bit0 = first bit received
//   pout_valid  out  1        pout holds an undelivered word
//   pout_ready  in   1        consumer takes pout this cycle
//   bit_cnt     out  CW       bits held in the shift register (WIDTH in FULL)

module shift_deserializer #(
  parameter int WIDTH = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       sin,
  input  logic                       sin_valid,
  output logic                       sin_ready,
  input  logic                       flush,
  output logic [WIDTH-1:0]           pout,
  output logic                       pout_valid,
  input  logic                       pout_ready,
  output logic [$clog2(WIDTH+1)-1:0] bit_cnt
);

  localparam int CW = $clog2(WIDTH+1);
  localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);
  localparam logic [CW-1:0] FULL_CNT = CW'(WIDTH);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t           r_state, w_state_nxt;
  logic [WIDTH-1:0] r_shreg, w_shreg_nxt;
  logic [CW-1:0]    r_cnt,   w_cnt_nxt;
  logic [WIDTH-1:0] r_pout,  w_pout_nxt;
  logic             r_pout_valid, w_pout_valid_nxt;

  logic             w_accept;
  logic             w_drain;
  logic             w_slot_free;
  logic [WIDTH-1:0] w_word;

  // Depends on state and flush only, so the upstream can compute sin_valid
  // from sin_ready without building a combinational loop.
  assign sin_ready   = !rst && (r_state != FULL) && !flush;

  assign w_accept    = sin_valid && sin_ready;
  assign w_drain     = r_pout_valid && pout_ready;
  assign w_slot_free = !r_pout_valid || pout_ready;
  assign w_word      = {sin, r_shreg[WIDTH-1:1]};

  always_comb begin
    w_state_nxt      = r_state;
    w_shreg_nxt      = r_shreg;
    w_cnt_nxt        = r_cnt;
    w_pout_nxt       = r_pout;
    w_pout_valid_nxt = r_pout_valid;

    // The output slot drains independently of the serial side; any branch
    // below that loads a new word sets valid again.
    if (w_drain) begin
      w_pout_valid_nxt = 1'b0;
    end

    if (flush) begin
      w_shreg_nxt = '0;
      w_cnt_nxt   = '0;
      w_state_nxt = IDLE;
    end else if (r_state == FULL) begin
      // The held word moves into the slot as the consumer takes the current
      // one, so valid stays high with no bubble.
      if (w_drain) begin
        w_pout_nxt       = r_shreg;
        w_pout_valid_nxt = 1'b1;
        w_shreg_nxt      = '0;
        w_cnt_nxt        = '0;
        w_state_nxt      = IDLE;
      end
    end else if (w_accept) begin
      if (r_cnt == LAST_CNT) begin
        if (w_slot_free) begin
          w_pout_nxt       = w_word;
          w_pout_valid_nxt = 1'b1;
          w_shreg_nxt      = '0;
          w_cnt_nxt        = '0;
          w_state_nxt      = IDLE;
        end else begin
          w_shreg_nxt = w_word;
          w_cnt_nxt   = FULL_CNT;
          w_state_nxt = FULL;
        end
      end else begin
        w_shreg_nxt = w_word;
        w_cnt_nxt   = r_cnt + CW'(1);
        w_state_nxt = SHIFT;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= IDLE;
      r_shreg      <= '0;
      r_cnt        <= '0;
      r_pout       <= '0;
      r_pout_valid <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_shreg      <= w_shreg_nxt;
      r_cnt        <= w_cnt_nxt;
      r_pout       <= w_pout_nxt;
      r_pout_valid <= w_pout_valid_nxt;
    end
  end

  assign pout       = r_pout;
  assign pout_valid = r_pout_valid;
  assign bit_cnt    = r_cnt;

endmodule

// File: tb/tb_shift_deserializer.sv
// tb/tb_shift_deserializer.sv - randomized self-checking bench for shift_deserializer
module tb_shift_deserializer;

  localparam int W  = 8;
  localparam int CW = $clog2(W+1);

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          sin = 1'b0;
  logic          sin_valid = 1'b0;
  logic          flush = 1'b0;
  logic          pout_ready = 1'b0;
  logic          sin_ready;
  logic          pout_valid;
  logic [W-1:0]  pout;
  logic [CW-1:0] bit_cnt;

  shift_deserializer #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .sin(sin), .sin_valid(sin_valid), .sin_ready(sin_ready),
    .flush(flush), .pout(pout), .pout_valid(pout_valid), .pout_ready(pout_ready),
    .bit_cnt(bit_cnt)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, act, exp);
  endtask

  // Reference model: bits collected so far, whether a finished word is
  // waiting behind the output slot, and the slot contents.
  int         m_n = 0;
  logic [W-1:0] m_word = '0;
  bit         m_held = 1'b0;
  logic [W-1:0] m_held_word = '0;
  bit         m_pv = 1'b0;
  logic [W-1:0] m_pout = '0;
  int         cyc_no = 0;
  int         pv_times[$];

  task automatic model_clear();
    m_n = 0; m_word = '0; m_held = 1'b0; m_held_word = '0; m_pv = 1'b0; m_pout = '0;
  endtask

  // Called at a negedge: applies inputs, checks the combinational ready,
  // advances the model across the posedge and checks registered outputs.
  task automatic cyc(input bit v, input bit b, input bit f, input bit r);
    bit exp_rdy, acc, old_pv;
    sin_valid = v; sin = b; flush = f; pout_ready = r;
    exp_rdy = !m_held && !f;
    #1;
    check("sin_ready", 32'(sin_ready), 32'(exp_rdy));
    @(posedge clk);
    acc    = v && exp_rdy;
    old_pv = m_pv;
    if (old_pv && r) m_pv = 1'b0;
    if (f) begin
      m_n = 0; m_word = '0; m_held = 1'b0;
    end else if (m_held) begin
      if (old_pv && r) begin
        m_pout = m_held_word; m_pv = 1'b1; m_held = 1'b0; m_n = 0;
      end
    end else if (acc) begin
      m_word[m_n] = b;
      m_n++;
      if (m_n == W) begin
        if (!old_pv || r) begin
          m_pout = m_word; m_pv = 1'b1; m_n = 0;
        end else begin
          m_held = 1'b1; m_held_word = m_word;
        end
        m_word = '0;
      end
    end
    #1;
    cyc_no++;
    check("pout_valid", 32'(pout_valid), 32'(m_pv));
    check("pout", 32'(pout), 32'(m_pout));
    check("bit_cnt", 32'(bit_cnt), 32'(m_n));
    if (pout_valid) pv_times.push_back(cyc_no);
    @(negedge clk);
  endtask

  task automatic send_word(input logic [W-1:0] w, input bit r);
    for (int i = 0; i < W; i++) cyc(1'b1, w[i], 1'b0, r);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #1;
    check("rst_pout", 32'(pout), 32'h0);
    check("rst_pout_valid", 32'(pout_valid), 32'h0);
    check("rst_bit_cnt", 32'(bit_cnt), 32'h0);
    check("rst_sin_ready", 32'(sin_ready), 32'h0);
    @(negedge clk);
    rst = 1'b0;
    model_clear();
  endtask

  initial begin
    @(negedge clk);
    do_reset();
    cyc(1'b0, 1'b0, 1'b0, 1'b0);

    // Single word with consumer ready: 1,0,1,0,0,1,0,1 -> 0xA5
    send_word(8'hA5, 1'b1);
    check("t1_pout", 32'(pout), 32'hA5);
    check("t1_valid", 32'(pout_valid), 32'h1);
    cyc(1'b0, 1'b0, 1'b0, 1'b1);
    check("t1_valid_pulse", 32'(pout_valid), 32'h0);

    // Reset in the middle of a word
    for (int i = 0; i < 3; i++) cyc(1'b1, 1'($urandom_range(0, 1)), 1'b0, 1'b1);
    do_reset();
    cyc(1'b0, 1'b0, 1'b0, 1'b0);

    // Stall: second word parks behind the first
    send_word(8'hA5, 1'b0);
    send_word(8'h3C, 1'b0);
    check("stall_pout", 32'(pout), 32'hA5);
    check("stall_bit_cnt", 32'(bit_cnt), 32'd8);
    check("stall_sin_ready", 32'(sin_ready), 32'h0);
    cyc(1'b0, 1'b0, 1'b0, 1'b1);
    check("stall_pout2", 32'(pout), 32'h3C);
    check("stall_valid2", 32'(pout_valid), 32'h1);
    check("stall_ready_back", 32'(sin_ready), 32'h1);
    cyc(1'b0, 1'b0, 1'b0, 1'b1);

    // Continuous stream of four words
    pv_times.delete();
    for (int k = 0; k < 4; k++) send_word(W'($urandom), 1'b1);
    cyc(1'b0, 1'b0, 1'b0, 1'b1);
    check("stream_pulses", 32'(pv_times.size()), 32'd4);
    for (int k = 1; k < pv_times.size(); k++)
      check("stream_spacing", 32'(pv_times[k] - pv_times[k-1]), 32'd8);

    // Flush of a partial word
    for (int i = 0; i < 5; i++) cyc(1'b1, 1'b0, 1'b0, 1'b1);
    cyc(1'b0, 1'b0, 1'b1, 1'b1);
    send_word(8'hFF, 1'b1);
    check("flush_pout", 32'(pout), 32'hFF);
    cyc(1'b0, 1'b0, 1'b0, 1'b1);

    // Flush while a word is held: the held word never appears
    send_word(8'h12, 1'b0);
    send_word(8'h34, 1'b0);
    cyc(1'b0, 1'b0, 1'b1, 1'b0);
    check("flushfull_bit_cnt", 32'(bit_cnt), 32'h0);
    cyc(1'b0, 1'b0, 1'b0, 1'b1);
    cyc(1'b0, 1'b0, 1'b0, 1'b1);
    check("flushfull_pout", 32'(pout), 32'h12);
    check("flushfull_valid", 32'(pout_valid), 32'h0);

    // Random gaps, stalls and occasional flushes
    for (int i = 0; i < 3000; i++)
      cyc($urandom_range(0, 2) != 0, 1'($urandom_range(0, 1)),
          $urandom_range(0, 60) == 0, $urandom_range(0, 3) != 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
